// File: rtl/mux_dff_pkg.sv
// mux_dff_pkg: shared helpers for the muxed DFF pipeline
package mux_dff_pkg;
   function automatic int sel_w(input int channels);
      return $clog2(channels);
   endfunction
endpackage

// File: rtl/mux_dff_stage.sv
// mux_dff_stage: one elastic valid/data register with flush
// ports: clk, rst_n (async low), flush, adv_next (downstream takes), in_v/in_data (from upstream),
//        adv (this stage loads this cycle), v/data (held word)
module mux_dff_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             adv_next,
   input  logic             in_v,
   input  logic [WIDTH-1:0] in_data,
   output logic             adv,
   output logic             v,
   output logic [WIDTH-1:0] data
);
   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] data;
   } ent_t;
   ent_t r;
   assign adv  = !r.v || adv_next;
   assign v    = r.v;
   assign data = r.data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r <= '0;
      else begin
         r.v <= !flush && (adv ? in_v : r.v);
         if (adv) r.data <= in_data;
      end
endmodule

// File: rtl/mux_dff_pipe.sv
// mux_dff_pipe: CHANNELS:1 word mux feeding a STAGES-deep valid/ready pipeline
// ports: clk, rst_n (async low), flush (clears valids), in_valid/in_ready/sel/d (upstream),
//        out_valid/out_ready/q (downstream), sel_err (sticky), err_cnt (saturating bad-select count)
module mux_dff_pipe import mux_dff_pkg::*; #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int STAGES   = 2,
   parameter int ECNT_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [sel_w(CHANNELS)-1:0] sel,
   input  logic [CHANNELS*WIDTH-1:0]  d,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           q,
   output logic                       sel_err,
   output logic [ECNT_W-1:0]          err_cnt
);
   logic [STAGES:0]              adv, cv;
   logic [STAGES:0][WIDTH-1:0]   cd;
   logic [STAGES-1:0]            v;
   logic [STAGES-1:0][WIDTH-1:0] sd;
   logic [WIDTH-1:0]             mux;
   logic                         bad, acc;
   // out-of-range selects fall through to zero
   always_comb begin
      mux = '0;
      for (int i = 0; i < CHANNELS; i++)
         if (int'(sel) == i) mux = d[i*WIDTH +: WIDTH];
   end
   assign bad         = int'(sel) >= CHANNELS;
   assign acc         = in_valid && in_ready && !flush;
   // chain views: index 0 is the upstream offer, index STAGES is the output
   assign cv          = {v, in_valid};
   assign cd          = {sd, mux};
   assign adv[STAGES] = out_ready;
   assign in_ready    = adv[0];
   assign out_valid   = cv[STAGES];
   assign q           = cd[STAGES];
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      mux_dff_stage #(.WIDTH(WIDTH)) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush    (flush),
         .adv_next (adv[k+1]),
         .in_v     (cv[k]),
         .in_data  (cd[k]),
         .adv      (adv[k]),
         .v        (v[k]),
         .data     (sd[k])
      );
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sel_err <= 1'b0;
         err_cnt <= '0;
      end else if (acc && bad) begin
         sel_err <= 1'b1;
         if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
endmodule

// File: tb/tb_mux_dff_pipe.sv
// tb_mux_dff_pipe: scoreboard bench over four builds sharing one stimulus stream
module tb_mux_dff_pipe;
   logic clk = 0, rst_n = 1, flush = 0, in_valid = 0, out_ready = 1;
   logic [1:0] sel = 0;
   logic [31:0] d = 32'h44332211;
   logic [3:0] ov, ir, se;
   logic [3:0][7:0] qq;
   logic [3:0][3:0] ec;
   int n_chk = 0, n_fail = 0, cyc = 0;
   bit lat_mode = 0;
   logic [7:0] sbd[4][$];
   int sbt[4][$];

   function automatic int ch_of(input int i);
      return i == 1 ? 3 : 4;
   endfunction
   function automatic int st_of(input int i);
      return i == 2 ? 1 : i == 3 ? 4 : 2;
   endfunction
   function automatic logic [7:0] exp_of(input int i, input logic [1:0] s);
      logic [7:0] tab [4];
      tab = '{8'h11, 8'h22, 8'h33, 8'h44};
      return int'(s) < ch_of(i) ? tab[s] : 8'h00;
   endfunction

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : u
      mux_dff_pipe #(.WIDTH(8), .CHANNELS(ch_of(g)), .STAGES(st_of(g)), .ECNT_W(4)) dut (
         .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[g]),
         .sel(sel), .d(d[ch_of(g)*8-1:0]), .out_valid(ov[g]), .out_ready(out_ready),
         .q(qq[g]), .sel_err(se[g]), .err_cnt(ec[g]));
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic mon_step();
      int t;
      for (int i = 0; i < 4; i++) begin
         if (!rst_n) begin
            sbd[i].delete();
            sbt[i].delete();
         end else begin
            if (ov[i] && out_ready) begin
               if (sbd[i].size() == 0) chk($sformatf("dut%0d_spurious_out", i), 32'(sbd[i].size() != 0), 1);
               else begin
                  chk($sformatf("dut%0d_q", i), qq[i], sbd[i].pop_front());
                  t = sbt[i].pop_front();
                  if (lat_mode) chk($sformatf("dut%0d_latency", i), cyc + 1 - t, st_of(i));
               end
            end
            if (flush) begin
               sbd[i].delete();
               sbt[i].delete();
            end else if (in_valid && ir[i]) begin
               sbd[i].push_back(exp_of(i, sel));
               sbt[i].push_back(cyc + 1);
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_dut%0d_out_valid", tag, i), ov[i], 0);
         chk($sformatf("%s_dut%0d_q", tag, i), qq[i], 0);
         chk($sformatf("%s_dut%0d_sel_err", tag, i), se[i], 0);
         chk($sformatf("%s_dut%0d_err_cnt", tag, i), ec[i], 0);
      end
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
      join_none
      #1 rst_n = 0;
      in_valid = 1;
      #1 chk_zero("reset");
      step();
      step();
      rst_n = 1;
      in_valid = 0;
      for (int i = 0; i < 4; i++) chk($sformatf("rel_dut%0d_in_ready", i), ir[i], 1);
      // streaming: all four channels back to back
      lat_mode = 1;
      for (int s = 0; s < 4; s++) begin
         in_valid = 1;
         sel = 2'(s);
         step();
      end
      in_valid = 0;
      repeat (6) step();
      lat_mode = 0;
      chk("stream_dut1_err_cnt", ec[1], 1);
      chk("stream_dut0_err_cnt", ec[0], 0);
      // backpressure
      out_ready = 0;
      in_valid = 1;
      sel = 0;
      step();
      sel = 1;
      chk("bp_in_ready_k1", ir[0], 1);
      for (int k = 2; k <= 5; k++) begin
         step();
         chk($sformatf("bp_in_ready_k%0d", k), ir[0], 0);
         chk($sformatf("bp_q_hold_k%0d", k), qq[0], 8'h11);
         chk($sformatf("bp_out_valid_k%0d", k), ov[0], 1);
      end
      out_ready = 1;
      in_valid = 0;
      repeat (8) step();
      // bad select stream
      sel = 3;
      in_valid = 1;
      repeat (20) step();
      in_valid = 0;
      repeat (6) step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("bad_dut%0d_sel_err", i), se[i], i == 1 ? 1 : 0);
         chk($sformatf("bad_dut%0d_err_cnt", i), ec[i], i == 1 ? 4'hF : 4'h0);
      end
      // flush with a concurrent offer
      out_ready = 0;
      in_valid = 1;
      sel = 0;
      step();
      step();
      flush = 1;
      sel = 2;
      step();
      flush = 0;
      in_valid = 0;
      for (int i = 0; i < 4; i++) chk($sformatf("flush_dut%0d_out_valid", i), ov[i], 0);
      chk("flush_dut1_err_kept", ec[1], 4'hF);
      out_ready = 1;
      in_valid = 1;
      sel = 1;
      step();
      in_valid = 0;
      repeat (6) step();
      // reset mid-stream
      out_ready = 0;
      in_valid = 1;
      sel = 2;
      step();
      step();
      #1 rst_n = 0;
      #1 chk_zero("midrst");
      step();
      rst_n = 1;
      for (int i = 0; i < 4; i++) chk($sformatf("midrel_dut%0d_in_ready", i), ir[i], 1);
      in_valid = 0;
      out_ready = 1;
      repeat (5) step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("post_dut%0d_out_valid", i), ov[i], 0);
         chk($sformatf("drain_dut%0d_pending", i), sbd[i].size(), 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
